// File: rtl/acc_trace_checker.sv
// Passive checker for the selector-driven dual accumulator. It compares each
// sample of (a, b, n, i) with the previous one and recovers the selector used
// for the step. It also counts ones and zeros, checks the closing invariants
// when i reaches n, and latches the first violation as a sticky error code.
module acc_trace_checker #(
  parameter int W      = 11,
  parameter int N_INIT = 200
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] n,
  input  logic [W-1:0] i,
  output logic         sel_rec,
  output logic         sel_valid,
  output logic [W-1:0] ones_cnt,
  output logic [W-1:0] zeros_cnt,
  output logic         done,
  output logic         err,
  output logic [2:0]   err_code,
  output logic [1:0]   state
);

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [W-1:0] NINIT = W'(N_INIT);
  localparam logic [W-1:0] D1    = W'(1);
  localparam logic [W-1:0] D2    = W'(2);

  state_t       state_q, state_d;
  logic [W-1:0] prev_a, prev_b, prev_n, prev_i;
  logic [W-1:0] da, db, di;
  logic [W-1:0] ones_d, zeros_d, cand_ones, cand_zeros;
  logic [2:0]   code_d;
  logic         sel_rec_d, sel_valid_d, done_d, capture;
  logic         step_one, step_zero, inv_sum_ok, inv_cnt_ok;

  // Step deltas, candidate counts and closing invariants. All of this is
  // modular in W bits: only equality mod 2^W matters, so wider intermediates
  // would hold no extra information.
  always_comb begin
    da         = a - prev_a;
    db         = b - prev_b;
    di         = i - prev_i;
    step_one   = (da == D1) && (db == D2);
    step_zero  = (da == D2) && (db == D1);
    cand_ones  = ones_cnt + {{(W-1){1'b0}}, step_one};
    cand_zeros = zeros_cnt + {{(W-1){1'b0}}, step_zero};
    inv_sum_ok = (a + b) == (n + n + n);
    inv_cnt_ok = ((cand_ones + cand_zeros) == n) &&
                 (a == cand_ones + cand_zeros + cand_zeros) &&
                 (b == cand_ones + cand_ones + cand_zeros);
  end

  // Next-state logic. Checks are applied in priority order. Any edge that
  // enters ERR leaves the counters and sel_valid untouched.
  always_comb begin
    state_d     = state_q;
    code_d      = err_code;
    ones_d      = ones_cnt;
    zeros_d     = zeros_cnt;
    sel_rec_d   = sel_rec;
    sel_valid_d = 1'b0;
    done_d      = done;
    capture     = 1'b0;
    case (state_q)
      S_WAIT: begin
        capture = 1'b1;
        if (a != '0 || b != '0 || i != '0 || n != NINIT) begin
          state_d = S_ERR;
          code_d  = 3'd1;
        end else if (n == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        capture = 1'b1;
        if (n != prev_n) begin
          state_d = S_ERR;
          code_d  = 3'd4;
        end else if (di != '0 && di != D1) begin
          state_d = S_ERR;
          code_d  = 3'd3;
        end else if (di == '0) begin
          // A stall is legal only if the values are unchanged.
          if (a != prev_a || b != prev_b) begin
            state_d = S_ERR;
            code_d  = 3'd2;
          end
        end else if (prev_i >= prev_n) begin
          state_d = S_ERR;
          code_d  = 3'd3;
        end else if (!(step_one || step_zero)) begin
          state_d = S_ERR;
          code_d  = 3'd2;
        end else if (i == n && !inv_sum_ok) begin
          state_d = S_ERR;
          code_d  = 3'd5;
        end else if (i == n && !inv_cnt_ok) begin
          state_d = S_ERR;
          code_d  = 3'd6;
        end else begin
          sel_rec_d   = step_one;
          sel_valid_d = 1'b1;
          ones_d      = cand_ones;
          zeros_d     = cand_zeros;
          if (i == n) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_DONE: begin
        // prev_* still hold the values seen at completion.
        if (a != prev_a || b != prev_b || n != prev_n || i != prev_i) begin
          state_d = S_ERR;
          code_d  = 3'd7;
          done_d  = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

  // State, output and previous-sample registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_WAIT;
      err_code  <= 3'd0;
      ones_cnt  <= '0;
      zeros_cnt <= '0;
      sel_rec   <= 1'b0;
      sel_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      prev_a    <= '0;
      prev_b    <= '0;
      prev_n    <= '0;
      prev_i    <= '0;
    end else begin
      state_q   <= state_d;
      err_code  <= code_d;
      ones_cnt  <= ones_d;
      zeros_cnt <= zeros_d;
      sel_rec   <= sel_rec_d;
      sel_valid <= sel_valid_d;
      done      <= done_d;
      err       <= (state_d == S_ERR);
      if (capture) begin
        prev_a <= a;
        prev_b <= b;
        prev_n <= n;
        prev_i <= i;
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_acc_trace_checker.sv
// Bench for acc_trace_checker. It builds accumulator traces from a selector
// sequence, with optional stalls, one injected fault or a reset. Expected
// outputs come from the scenario itself: running selector counts, and a
// freeze at the fault with the code that the fault type implies.
module tb_acc_trace_checker;

  localparam int W = 11;
  localparam int N = 200;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a, b, n, i;
  logic         sel_rec, sel_valid, done, err;
  logic [W-1:0] ones_cnt, zeros_cnt;
  logic [2:0]   err_code;
  logic [1:0]   state;

  int n_checks = 0;
  int n_errors = 0;
  int pulse_cnt;

  // Expected values held by the scenario model.
  int e_ones, e_zeros, e_selrec, e_done, e_err, e_code, e_state;

  always #5 clk = ~clk;

  acc_trace_checker #(.W(W), .N_INIT(N)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .n(n), .i(i),
    .sel_rec(sel_rec), .sel_valid(sel_valid), .ones_cnt(ones_cnt),
    .zeros_cnt(zeros_cnt), .done(done), .err(err), .err_code(err_code),
    .state(state)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input int ev);
    chk("sel_valid", int'(sel_valid), ev);
    chk("sel_rec",   int'(sel_rec),   e_selrec);
    chk("ones_cnt",  int'(ones_cnt),  e_ones);
    chk("zeros_cnt", int'(zeros_cnt), e_zeros);
    chk("done",      int'(done),      e_done);
    chk("err",       int'(err),       e_err);
    chk("err_code",  int'(err_code),  e_code);
    chk("state",     int'(state),     e_state);
  endtask

  // Take one sample edge, then check just after it.
  task automatic apply_sample(input int ev);
    @(posedge clk);
    #1;
    if (sel_valid) pulse_cnt++;
    check_outputs(ev);
  endtask

  task automatic model_clear();
    e_ones = 0; e_zeros = 0; e_selrec = 0; e_done = 0;
    e_err = 0; e_code = 0; e_state = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a = W'($urandom); b = W'($urandom); n = W'($urandom); i = W'($urandom);
    model_clear();
    apply_sample(0);
    rst = 1'b0;
    pulse_cnt = 0;
  endtask

  task automatic enter_err(input int code);
    e_err = 1; e_code = code; e_state = 3; e_done = 0;
    apply_sample(0);
    // Errors are sticky: random input activity must change nothing.
    for (int c = 0; c < 4; c++) begin
      a = W'($urandom); b = W'($urandom); n = W'($urandom); i = W'($urandom);
      apply_sample(0);
    end
  endtask

  // mode: 0 all ones, 1 alternating 1/0, 2 random.
  // fault: 0 none, 1 bad first sample, 2 a jumps, 3 i jumps by 2,
  //        4 n changes, 7 change after done, 8 stall with a changed.
  task automatic run(input int mode, input int n_stall, input int fault,
                     input int fstep, input int rst_step);
    bit stall_at [1:N];
    int placed;
    int sel;
    for (int k = 1; k <= N; k++) stall_at[k] = 1'b0;
    placed = 0;
    while (placed < n_stall) begin
      int p = int'($urandom_range(1, N));
      if (!stall_at[p]) begin stall_at[p] = 1'b1; placed++; end
    end
    a = '0; b = '0; i = '0; n = W'(N);
    if (fault == 1) begin
      n = W'(N - 1);
      enter_err(1);
      return;
    end
    e_state = 1;
    apply_sample(0);
    for (int k = 1; k <= N; k++) begin
      if (k == rst_step) begin
        do_reset();
        return;
      end
      if (stall_at[k]) apply_sample(0);
      sel = (mode == 0) ? 1 : (mode == 1) ? (k % 2) : int'($urandom_range(0, 1));
      if (k == fstep) begin
        case (fault)
          2: begin i = W'(k); a = a + W'(3); b = b + W'(sel ? 2 : 1); end
          3: begin i = W'(k + 1); a = a + W'(sel ? 1 : 2); b = b + W'(sel ? 2 : 1); end
          4: begin i = W'(k); n = W'(N + 1); a = a + W'(sel ? 1 : 2); b = b + W'(sel ? 2 : 1); end
          default: a = a + W'(1);
        endcase
        enter_err((fault == 8) ? 2 : fault);
        return;
      end
      i = W'(k);
      a = a + W'(sel ? 1 : 2);
      b = b + W'(sel ? 2 : 1);
      if (sel == 1) e_ones++; else e_zeros++;
      e_selrec = sel;
      if (k == N) begin e_done = 1; e_state = 2; end
      apply_sample(1);
    end
    for (int c = 0; c < 3; c++) apply_sample(0);
    if (fault == 7) begin
      a = a + W'(1);
      enter_err(7);
    end
  endtask

  initial begin
    rst = 1'b0;
    a = '0; b = '0; n = '0; i = '0;
    pulse_cnt = 0;
    model_clear();

    do_reset();
    run(0, 0, 0, 0, 0);
    chk("run0_a", int'(a), 200);
    chk("run0_b", int'(b), 400);

    do_reset();
    run(1, 3, 0, 0, 0);
    chk("alt_pulses", pulse_cnt, 200);

    do_reset(); run(2, 2, 2, 5, 0);
    do_reset(); run(2, 2, 4, 10, 0);
    do_reset(); run(2, 2, 3, 10, 0);
    do_reset(); run(2, 4, 7, 0, 0);
    do_reset(); run(2, 0, 1, 0, 0);
    do_reset(); run(2, 2, 8, int'($urandom_range(2, N)), 0);

    do_reset();
    run(2, 2, 0, 0, 50);
    run(2, 3, 0, 0, 0);
    chk("fresh_done", int'(done), 1);

    // Extra random faults at random steps.
    for (int r = 0; r < 4; r++) begin
      int f;
      case ($urandom_range(0, 3))
        0: f = 2;
        1: f = 3;
        2: f = 4;
        default: f = 8;
      endcase
      do_reset();
      run(2, int'($urandom_range(0, 4)), f, int'($urandom_range(2, N)), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
